// File: rtl/red_pitaya_exp_seq_pkg.sv
// Shared definitions for the expansion-connector pattern sequencer:
// FSM state encoding, bus register offsets (within sys_addr[19:0]) and
// the pattern-window address decoder.
package red_pitaya_exp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    localparam logic [19:0] ADDR_CTRL     = 20'h00000;
    localparam logic [19:0] ADDR_STATUS   = 20'h00004;
    localparam logic [19:0] ADDR_PERIOD   = 20'h00008;
    localparam logic [19:0] ADDR_LEN      = 20'h0000C;
    localparam logic [19:0] ADDR_LOOPS    = 20'h00010;
    localparam logic [19:0] ADDR_PAT_BASE = 20'h01000;

    // True when addr falls on a word of the 2^aw-entry pattern window.
    function automatic logic is_pat_addr(input logic [19:0] addr, input int unsigned aw);
        logic [19:0] mask;
        mask = ((20'd1 << aw) - 20'd1) << 2;
        return (addr & ~mask) == ADDR_PAT_BASE;
    endfunction

endpackage

// File: rtl/red_pitaya_exp_seq_mem.sv
// Pattern table: 2^AW x DW register file, not reset.
//   i_clk        clock
//   i_we         bus write enable
//   i_waddr      bus write index
//   i_wdata      bus write word {N, P}
//   i_bus_raddr  bus read index (async read -> o_bus_rdata)
//   i_seq_raddr  sequencer read index (async read -> o_seq_rdata)
module red_pitaya_exp_seq_mem #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_bus_raddr,
    output logic [DW-1:0] o_bus_rdata,
    input  logic [AW-1:0] i_seq_raddr,
    output logic [DW-1:0] o_seq_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_bus_rdata = r_mem[i_bus_raddr];
    assign o_seq_rdata = r_mem[i_seq_raddr];

endmodule

// File: rtl/red_pitaya_exp_seq.sv
// Expansion-connector pattern sequencer. Plays the pattern table onto
// seq_p_dat_o / seq_n_dat_o with programmable dwell, length and repeat
// count, optionally armed on a trig_i rising edge.
//   clk_i, rst_i      clock, synchronous active-high reset
//   trig_i            external trigger (synchronous)
//   seq_p/n_dat_o     pattern outputs (registered, hold outside RUN)
//   seq_active_o      high in ARM or RUN
//   done_o            one-cycle pulse on normal completion
//   sys_*             system bus slave, ack one cycle after wen|ren
module red_pitaya_exp_seq
    import red_pitaya_exp_seq_pkg::*;
#(
    parameter int unsigned DWE = 8,
    parameter int unsigned AW  = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           trig_i,
    output logic [DWE-1:0] seq_p_dat_o,
    output logic [DWE-1:0] seq_n_dat_o,
    output logic           seq_active_o,
    output logic           done_o,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic [3:0]     sys_sel,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_err,
    output logic           sys_ack
);

    seq_state_e r_state, w_state_nx;

    logic [31:0]    r_period;
    logic [AW-1:0]  r_len;
    logic [15:0]    r_loops;
    logic           r_trig_en;
    logic           r_loop_inf;
    logic [31:0]    r_dwell;
    logic [AW-1:0]  r_step;
    logic [15:0]    r_pass;
    logic           r_trig_q;
    logic [DWE-1:0] r_p_dat;
    logic [DWE-1:0] r_n_dat;
    logic           r_done;
    logic           r_ack;
    logic [31:0]    r_rdata;

    logic [19:0]      w_addr;
    logic             w_wr_ctrl;
    logic             w_start;
    logic             w_stop;
    logic             w_cfg_we;
    logic             w_pat_sel;
    logic             w_pat_we;
    logic [AW-1:0]    w_pat_idx;
    logic [2*DWE-1:0] w_bus_word;
    logic [2*DWE-1:0] w_seq_word;
    logic             w_trig_rise;
    logic             w_dwell_end;
    logic             w_step_last;
    logic             w_pass_last;
    logic             w_active;
    logic             w_run;
    logic             w_launch;
    logic             w_complete;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_addr      = sys_addr[19:0];
    assign w_wr_ctrl   = sys_wen && (w_addr == ADDR_CTRL);
    assign w_start     = w_wr_ctrl && sys_wdata[0];
    assign w_stop      = w_wr_ctrl && sys_wdata[1];
    assign w_cfg_we    = sys_wen && (r_state == ST_IDLE);
    assign w_pat_sel   = is_pat_addr(w_addr, AW);
    assign w_pat_we    = sys_wen && w_pat_sel;
    assign w_pat_idx   = w_addr[AW+1:2];
    assign w_trig_rise = trig_i && !r_trig_q;
    assign w_dwell_end = (r_dwell == r_period);
    assign w_step_last = (r_step == r_len);
    assign w_pass_last = !r_loop_inf && (r_pass == r_loops);
    assign w_unused    = ^{sys_sel, sys_addr[31:20]};

    red_pitaya_exp_seq_mem #(
        .DW (2*DWE),
        .AW (AW)
    ) u_mem (
        .i_clk       (clk_i),
        .i_we        (w_pat_we),
        .i_waddr     (w_pat_idx),
        .i_wdata     ({sys_wdata[DWE+15:16], sys_wdata[DWE-1:0]}),
        .i_bus_raddr (w_pat_idx),
        .o_bus_rdata (w_bus_word),
        .i_seq_raddr (r_step),
        .o_seq_rdata (w_seq_word)
    );

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM: next state. The start decision uses the trig_en bit carried in
    // the same CTRL write, since that write also loads the register.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start) w_state_nx = sys_wdata[2] ? ST_ARM : ST_RUN;
            ST_ARM:  if (w_trig_rise) w_state_nx = ST_RUN;
            ST_RUN:  if (w_dwell_end && w_step_last && w_pass_last) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_stop) begin
            w_state_nx = ST_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        w_active   = (r_state == ST_ARM) || (r_state == ST_RUN);
        w_run      = (r_state == ST_RUN);
        w_launch   = (r_state == ST_IDLE) && w_start && !w_stop;
        w_complete = w_run && w_dwell_end && w_step_last && w_pass_last && !w_stop;
    end

    // Dwell / step / pass counters; frozen on stop so STATUS shows where it halted.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_launch) begin
            r_dwell <= '0;
            r_step  <= '0;
            r_pass  <= '0;
        end else if (w_run && !w_stop) begin
            if (w_dwell_end) begin
                r_dwell <= '0;
                if (w_step_last) begin
                    r_step <= '0;
                    if (!w_pass_last) begin
                        r_pass <= r_pass + 16'd1;
                    end
                end else begin
                    r_step <= r_step + AW'(1);
                end
            end else begin
                r_dwell <= r_dwell + 32'd1;
            end
        end
    end

    // Configuration registers, writable only while IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_period   <= '0;
            r_len      <= '0;
            r_loops    <= '0;
            r_trig_en  <= 1'b0;
            r_loop_inf <= 1'b0;
        end else if (w_cfg_we) begin
            if (w_addr == ADDR_CTRL) begin
                r_trig_en  <= sys_wdata[2];
                r_loop_inf <= sys_wdata[3];
            end
            if (w_addr == ADDR_PERIOD) r_period <= sys_wdata;
            if (w_addr == ADDR_LEN)    r_len    <= sys_wdata[AW-1:0];
            if (w_addr == ADDR_LOOPS)  r_loops  <= sys_wdata[15:0];
        end
    end

    // Pattern outputs, done pulse, trigger history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_p_dat  <= '0;
            r_n_dat  <= '0;
            r_done   <= 1'b0;
            r_trig_q <= 1'b0;
        end else begin
            if (w_run) begin
                r_p_dat <= w_seq_word[DWE-1:0];
                r_n_dat <= w_seq_word[2*DWE-1:DWE];
            end
            r_done   <= w_complete;
            r_trig_q <= trig_i;
        end
    end

    // Bus read decode
    always_comb begin
        w_rd = '0;
        if (w_addr == ADDR_CTRL) begin
            w_rd[2] = r_trig_en;
            w_rd[3] = r_loop_inf;
        end else if (w_addr == ADDR_STATUS) begin
            w_rd[1:0]    = r_state;
            w_rd[AW+7:8] = r_step;
            w_rd[31:16]  = r_pass;
        end else if (w_addr == ADDR_PERIOD) begin
            w_rd = r_period;
        end else if (w_addr == ADDR_LEN) begin
            w_rd[AW-1:0] = r_len;
        end else if (w_addr == ADDR_LOOPS) begin
            w_rd[15:0] = r_loops;
        end else if (w_pat_sel) begin
            w_rd[DWE-1:0]   = w_bus_word[DWE-1:0];
            w_rd[DWE+15:16] = w_bus_word[2*DWE-1:DWE];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= sys_wen || sys_ren;
            r_rdata <= sys_ren ? w_rd : '0;
        end
    end

    assign seq_p_dat_o  = r_p_dat;
    assign seq_n_dat_o  = r_n_dat;
    assign seq_active_o = w_active;
    assign done_o       = r_done;
    assign sys_rdata    = r_rdata;
    assign sys_ack      = r_ack;
    assign sys_err      = 1'b0;

endmodule

// File: tb/tb_red_pitaya_exp_seq.sv
// Bench for red_pitaya_exp_seq: directed and randomized runs checked
// against an expected output stream built from nested pass/step/dwell loops.
module tb_red_pitaya_exp_seq;

    localparam int DWE = 8;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           trig_i = 1'b0;
    logic [DWE-1:0] seq_p_dat_o;
    logic [DWE-1:0] seq_n_dat_o;
    logic           seq_active_o;
    logic           done_o;
    logic [31:0]    sys_addr = '0;
    logic [31:0]    sys_wdata = '0;
    logic [3:0]     sys_sel = 4'hF;
    logic           sys_wen = 1'b0;
    logic           sys_ren = 1'b0;
    logic [31:0]    sys_rdata;
    logic           sys_err;
    logic           sys_ack;

    red_pitaya_exp_seq #(.DWE(DWE), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .trig_i       (trig_i),
        .seq_p_dat_o  (seq_p_dat_o),
        .seq_n_dat_o  (seq_n_dat_o),
        .seq_active_o (seq_active_o),
        .done_o       (done_o),
        .sys_addr     (sys_addr),
        .sys_wdata    (sys_wdata),
        .sys_sel      (sys_sel),
        .sys_wen      (sys_wen),
        .sys_ren      (sys_ren),
        .sys_rdata    (sys_rdata),
        .sys_err      (sys_err),
        .sys_ack      (sys_ack)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DWE-1:0] pat_p [16];
    logic [DWE-1:0] pat_n [16];
    logic [15:0]    exp_q [$];
    logic [15:0]    last_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(posedge clk); #1;
        sys_wen = 1'b0;
        chk("wr_ack", {31'd0, sys_ack}, 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        @(posedge clk); #1;
        sys_ren = 1'b0;
        d = sys_rdata;
        chk("rd_ack", {31'd0, sys_ack}, 32'd1);
    endtask

    task automatic set_pattern(input int k, input logic [7:0] p, input logic [7:0] n);
        bus_write(32'h1000 + 32'(4 * k), {8'h00, n, 8'h00, p});
        pat_p[k] = p;
        pat_n[k] = n;
    endtask

    task automatic cfg(input int unsigned per, input int unsigned len, input int unsigned loops);
        bus_write(32'h08, per);
        bus_write(32'h0C, len);
        bus_write(32'h10, loops);
    endtask

    // Expected output stream: each pass visits steps 0..len, each held per+1 clocks.
    task automatic build(input int unsigned per, input int unsigned len, input int unsigned loops);
        exp_q.delete();
        for (int unsigned ps = 0; ps <= loops; ps++)
            for (int unsigned s = 0; s <= len; s++)
                for (int unsigned r = 0; r <= per; r++)
                    exp_q.push_back({pat_n[s], pat_p[s]});
    endtask

    // Entered #1 after the edge that puts the sequencer in RUN.
    task automatic check_run(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_active0"}, {31'd0, seq_active_o}, 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            chk({tag, "_p"}, {24'd0, seq_p_dat_o}, {24'd0, exp_q[k-1][7:0]});
            chk({tag, "_n"}, {24'd0, seq_n_dat_o}, {24'd0, exp_q[k-1][15:8]});
            chk({tag, "_done"}, {31'd0, done_o}, {31'd0, k == n});
            chk({tag, "_active"}, {31'd0, seq_active_o}, {31'd0, k < n});
        end
        last_word = exp_q[n-1];
        @(posedge clk); #1;
        chk({tag, "_done_after"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_hold"}, {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, last_word});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned per, len, loops;
        int unsigned kstop;
        bit seen;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p", {24'd0, seq_p_dat_o}, 32'd0);
        chk("rst_n", {24'd0, seq_n_dat_o}, 32'd0);
        chk("rst_active", {31'd0, seq_active_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_ack", {31'd0, sys_ack}, 32'd0);
        chk("err", {31'd0, sys_err}, 32'd0);
        @(negedge clk); rst_i = 1'b0;
        bus_read(32'h04, rd);  chk("rst_status", rd, 32'd0);
        bus_read(32'h08, rd);  chk("rst_period", rd, 32'd0);
        bus_read(32'h0C, rd);  chk("rst_len", rd, 32'd0);
        bus_read(32'h200, rd); chk("unmapped", rd, 32'd0);
        @(posedge clk); #1;
        chk("ack_drop", {31'd0, sys_ack}, 32'd0);

        // ---- basic single pass
        for (int k = 0; k < 16; k++) set_pattern(k, 8'($urandom), 8'($urandom));
        set_pattern(0, 8'h01, 8'($urandom));
        set_pattern(1, 8'h02, 8'($urandom));
        set_pattern(2, 8'h04, 8'($urandom));
        set_pattern(3, 8'h08, 8'($urandom));
        cfg(2, 3, 0);
        bus_read(32'h08, rd); chk("period_rb", rd, 32'd2);
        bus_read(32'h0C, rd); chk("len_rb", rd, 32'd3);
        bus_read(32'h1004, rd); chk("pat1_rb", rd, {8'h00, pat_n[1], 8'h00, 8'h02});
        build(2, 3, 0);
        bus_write(32'h00, 32'h1);
        check_run("single");
        bus_read(32'h04, rd);
        chk("single_state", {30'd0, rd[1:0]}, 32'd0);
        chk("single_pass", {16'd0, rd[31:16]}, 32'd0);

        // ---- three passes
        cfg(2, 3, 2);
        build(2, 3, 2);
        bus_write(32'h00, 32'h1);
        check_run("loops");
        bus_read(32'h04, rd);
        chk("loops_state", {30'd0, rd[1:0]}, 32'd0);
        chk("loops_pass", {16'd0, rd[31:16]}, 32'd2);

        // ---- randomized runs; first one pins PERIOD=0, LEN=0
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                per = 0; len = 0; loops = 1;
            end else begin
                per = $urandom_range(0, 3); len = $urandom_range(0, 6); loops = $urandom_range(0, 2);
            end
            for (int k = 0; k <= int'(len); k++) set_pattern(k, 8'($urandom), 8'($urandom));
            bus_read(32'h1000 + 32'(4 * len), rd);
            chk("rand_pat_rb", rd, {8'h00, pat_n[len], 8'h00, pat_p[len]});
            cfg(per, len, loops);
            build(per, len, loops);
            bus_write(32'h00, 32'h1);
            check_run("rand");
            bus_read(32'h04, rd);
            chk("rand_state", {30'd0, rd[1:0]}, 32'd0);
            chk("rand_pass", {16'd0, rd[31:16]}, loops);
        end

        // ---- trigger arm
        cfg(1, 2, 0);
        bus_write(32'h00, 32'h5);
        chk("arm_active", {31'd0, seq_active_o}, 32'd1);
        bus_read(32'h04, rd); chk("arm_status", rd, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("arm_hold", {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, last_word});
        @(negedge clk); trig_i = 1'b1;
        @(posedge clk); #1;
        build(1, 2, 0);
        check_run("trig");
        // trig_i still high: a fresh arm must wait for a new rising edge
        bus_write(32'h00, 32'h5);
        repeat (4) @(posedge clk);
        #1;
        chk("rearm_active", {31'd0, seq_active_o}, 32'd1);
        chk("rearm_hold", {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, last_word});
        bus_read(32'h04, rd); chk("rearm_status", {30'd0, rd[1:0]}, 32'd1);
        @(negedge clk); trig_i = 1'b0;
        @(negedge clk); trig_i = 1'b1;
        @(posedge clk); #1;
        check_run("trig2");
        @(negedge clk); trig_i = 1'b0;
        bus_write(32'h00, 32'h0);

        // ---- infinite loop then stop mid-step
        bus_write(32'h00, 32'h9);
        kstop = 15;
        for (int k = 1; k <= int'(kstop); k++) begin
            @(posedge clk); #1;
            chk("inf_out", {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, exp_q[(k-1) % exp_q.size()]});
            chk("inf_done", {31'd0, done_o}, 32'd0);
        end
        bus_write(32'h00, 32'h2);
        chk("stop_active", {31'd0, seq_active_o}, 32'd0);
        chk("stop_done", {31'd0, done_o}, 32'd0);
        last_word = exp_q[kstop % exp_q.size()];
        chk("stop_out", {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, last_word});
        repeat (3) begin
            @(posedge clk); #1;
            chk("stop_done_later", {31'd0, done_o}, 32'd0);
            chk("stop_hold", {16'd0, seq_n_dat_o, seq_p_dat_o}, {16'd0, last_word});
        end
        // 6-clock passes (3 steps x 2 clocks): stopped at pass 2, step 1
        bus_read(32'h04, rd); chk("stop_status", rd, 32'h0002_0100);
        bus_write(32'h00, 32'h0);

        // ---- start and stop together
        bus_write(32'h00, 32'h3);
        chk("startstop_active", {31'd0, seq_active_o}, 32'd0);
        bus_read(32'h04, rd); chk("startstop_state", {30'd0, rd[1:0]}, 32'd0);

        // ---- config writes dropped during RUN, pattern writes take effect
        cfg(2, 3, 3);
        bus_write(32'h00, 32'h1);
        bus_write(32'h08, 32'h7);
        bus_write(32'h0C, 32'h1);
        bus_read(32'h08, rd); chk("run_period_locked", rd, 32'd2);
        bus_read(32'h0C, rd); chk("run_len_locked", rd, 32'd3);
        set_pattern(0, ~pat_p[1], 8'hC3);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            if (seq_p_dat_o === pat_p[0] && seq_n_dat_o === 8'hC3) seen = 1'b1;
        end
        chk("pat_live_update", {31'd0, seen}, 32'd1);

        // ---- reset mid-run
        repeat (3) @(posedge clk);
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;
        chk("midrst_p", {24'd0, seq_p_dat_o}, 32'd0);
        chk("midrst_n", {24'd0, seq_n_dat_o}, 32'd0);
        chk("midrst_active", {31'd0, seq_active_o}, 32'd0);
        @(negedge clk); rst_i = 1'b0;
        bus_read(32'h08, rd); chk("midrst_period", rd, 32'd0);
        bus_read(32'h04, rd); chk("midrst_status", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
